// File: rtl/lsu_mem_if.sv
// lsu_mem_if: request/memory/response bundle for lsu_mem_ctrl; slave = controller side, master = requester plus memory side
interface lsu_mem_if #(parameter int ADDR_W = 32);
  logic req_valid;
  logic req_ready;
  logic [5:0] req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic mem_en;
  logic [3:0] mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic mem_ack;
  logic rsp_valid;
  logic [31:0] rsp_data;
  logic rsp_err;
  logic rsp_timeout;
  modport slave (
    input req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_rdata, mem_ack,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err, rsp_timeout
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_rdata, mem_ack,
    input req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MIPS MEM-stage load/store sequencer; ports clk, rst_n (sync active-low), bus (lsu_mem_if.slave: req/mem/rsp); define LSU_UNALIGNED_EN to enable LWL/LWR
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic clk,
  input logic rst_n,
  lsu_mem_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [5:0] op;
  logic [1:0] lane_i, lane_c;
  logic [CW-1:0] cnt;
  logic [3:0] we_i, we_r;
  logic [ADDR_W-3:0] maddr_r;
  logic [31:0] wd_i, wd_r, data_r, ld, ld_ua;
  logic [7:0] b;
  logic [15:0] h;
  logic legal_i, err_i, err_r, to_r, accept, timeout;
  assign lane_i = bus.req_addr[1:0] ^ {2{BIG_ENDIAN}};
`ifdef LSU_UNALIGNED_EN
  assign legal_i = bus.req_op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B};
`else
  assign legal_i = bus.req_op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
`endif
  assign err_i = !legal_i
    || ((bus.req_op inside {6'h21, 6'h25, 6'h29}) && bus.req_addr[0])
    || ((bus.req_op inside {6'h23, 6'h2B}) && bus.req_addr[1:0] != 2'b00);
  assign we_i = bus.req_op == 6'h28 ? 4'b0001 << lane_i
              : bus.req_op == 6'h29 ? (lane_i[1] ? 4'b1100 : 4'b0011)
              : bus.req_op == 6'h2B ? 4'b1111 : 4'b0000;
  assign wd_i = bus.req_op == 6'h28 ? {4{bus.req_wdata[7:0]}}
              : bus.req_op == 6'h29 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign b = bus.mem_rdata[{lane_c, 3'b000} +: 8];
  assign h = bus.mem_rdata[{lane_c[1], 4'b0000} +: 16];
`ifdef LSU_UNALIGNED_EN
  logic [31:0] rt_old, rd;
  assign rd = bus.mem_rdata;
  assign ld_ua = op == 6'h22 ? (lane_c == 2'd0 ? {rd[7:0], rt_old[23:0]}
                              : lane_c == 2'd1 ? {rd[15:0], rt_old[15:0]}
                              : lane_c == 2'd2 ? {rd[23:0], rt_old[7:0]} : rd)
               : op == 6'h26 ? (lane_c == 2'd0 ? rd
                              : lane_c == 2'd1 ? {rt_old[31:24], rd[31:8]}
                              : lane_c == 2'd2 ? {rt_old[31:16], rd[31:16]} : {rt_old[31:8], rd[31:24]})
               : 32'h0;
  always_ff @(posedge clk)
    rt_old <= !rst_n ? 32'h0 : accept ? bus.req_rt_old : rt_old;
`else
  assign ld_ua = 32'h0;
`endif
  assign ld = op == 6'h20 ? {{24{b[7]}}, b}
            : op == 6'h24 ? {24'h0, b}
            : op == 6'h21 ? {{16{h[15]}}, h}
            : op == 6'h25 ? {16'h0, h}
            : op == 6'h23 ? bus.mem_rdata : ld_ua;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;
  always_comb begin
    accept = state == IDLE && bus.req_valid;
    timeout = state == WAIT && !bus.mem_ack && cnt == TMAX;
    state_n = state == IDLE ? (bus.req_valid ? (err_i ? RESP : WAIT) : IDLE)
            : state == WAIT ? ((bus.mem_ack || cnt == TMAX) ? RESP : WAIT) : IDLE;
    bus.req_ready = state == IDLE;
    bus.mem_en = state == WAIT;
    bus.rsp_valid = state == RESP;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      op <= 6'h0;
      lane_c <= 2'h0;
      cnt <= '0;
      we_r <= 4'h0;
      maddr_r <= '0;
      wd_r <= 32'h0;
      data_r <= 32'h0;
      err_r <= 1'b0;
      to_r <= 1'b0;
    end else if (accept) begin
      op <= bus.req_op;
      lane_c <= lane_i;
      cnt <= '0;
      we_r <= err_i ? 4'h0 : we_i;
      maddr_r <= bus.req_addr[ADDR_W-1:2];
      wd_r <= wd_i;
      data_r <= 32'h0;
      err_r <= err_i;
      to_r <= 1'b0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
      data_r <= bus.mem_ack ? ld : 32'h0;
      to_r <= timeout;
    end
  assign bus.mem_we = we_r;
  assign bus.mem_addr = maddr_r;
  assign bus.mem_wdata = wd_r;
  assign bus.rsp_data = data_r;
  assign bus.rsp_err = err_r;
  assign bus.rsp_timeout = to_r;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: table-driven plus randomized self-checking bench for lsu_mem_ctrl (little- and big-endian instances, TIMEOUT=4)
module tb_lsu_mem_ctrl;
  localparam int TMO = 4;
  typedef struct packed {
    logic [31:0] data;
    logic err;
    logic [3:0] we;
    logic [31:0] wd;
  } exp_t;
  typedef struct packed {
    logic [5:0] op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rt;
    logic [31:0] rd;
    int ack;
    logic [31:0] data;
    logic err;
    logic [3:0] we;
    logic [31:0] mwd;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic mem_ack = 1'b0;
  logic [5:0] req_op = 6'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, req_rt_old = 32'h0, mem_rdata = 32'h0;
  int checks = 0;
  int failures = 0;
  logic [1:0] rdy, en, rv, er, tm;
  logic [3:0] we [2];
  logic [29:0] mad [2];
  logic [31:0] mwd [2];
  logic [31:0] rd_o [2];
  lsu_mem_if #(.ADDR_W(32)) b0 ();
  lsu_mem_if #(.ADDR_W(32)) b1 ();
  assign {b0.req_valid, b0.req_op, b0.req_addr, b0.req_wdata, b0.req_rt_old, b0.mem_rdata, b0.mem_ack} =
         {req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_rdata, mem_ack};
  assign {b1.req_valid, b1.req_op, b1.req_addr, b1.req_wdata, b1.req_rt_old, b1.mem_rdata, b1.mem_ack} =
         {req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_rdata, mem_ack};
  assign rdy = {b1.req_ready, b0.req_ready};
  assign en = {b1.mem_en, b0.mem_en};
  assign rv = {b1.rsp_valid, b0.rsp_valid};
  assign er = {b1.rsp_err, b0.rsp_err};
  assign tm = {b1.rsp_timeout, b0.rsp_timeout};
  assign we[0] = b0.mem_we;
  assign we[1] = b1.mem_we;
  assign mad[0] = b0.mem_addr;
  assign mad[1] = b1.mem_addr;
  assign mwd[0] = b0.mem_wdata;
  assign mwd[1] = b1.mem_wdata;
  assign rd_o[0] = b0.rsp_data;
  assign rd_o[1] = b1.rsp_data;
  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TMO), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TMO), .BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rt, input logic [31:0] rd, input bit be);
    exp_t e;
    int o;
    logic [31:0] bt, hw;
    e = '0;
    o = be ? 3 - int'(a[1:0]) : int'(a[1:0]);
    bt = (rd >> (8 * o)) & 32'hFF;
    hw = (rd >> (16 * (o / 2))) & 32'hFFFF;
    case (op)
      6'h20: e.data = bt > 127 ? bt - 32'd256 : bt;
      6'h24: e.data = bt;
      6'h21: e.data = hw > 32767 ? hw - 32'd65536 : hw;
      6'h25: e.data = hw;
      6'h23: e.data = rd;
      6'h28: begin e.we = 4'(1 << o); e.wd = (wd & 32'hFF) * 32'h0101_0101; end
      6'h29: begin e.we = 4'(3 << (2 * (o / 2))); e.wd = (wd & 32'hFFFF) * 32'h0001_0001; end
      6'h2B: begin e.we = 4'hF; e.wd = wd; end
`ifdef LSU_UNALIGNED_EN
      6'h22: e.data = 32'(({32'h0, rd} << (8 * (3 - o))) | ({32'h0, rt} & ((64'd1 << (8 * (3 - o))) - 64'd1)));
      6'h26: e.data = (rd >> (8 * o)) | (rt & ~(32'hFFFF_FFFF >> (8 * o)));
`endif
      default: e.err = 1'b1;
    endcase
    if ((op == 6'h21 || op == 6'h25 || op == 6'h29) && a[0]) e.err = 1'b1;
    if ((op == 6'h23 || op == 6'h2B) && a[1:0] != 2'b00) e.err = 1'b1;
    if (e.err) begin
      e.data = 32'h0;
      e.we = 4'h0;
      e.wd = 32'h0;
    end
    return e;
  endfunction
  task automatic run_txn(input string nm, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rt, input logic [31:0] rd, input int ack_at, input exp_t e0, input exp_t e1);
    exp_t e [2];
    int en_n [2], rsp_n [2], rsp_c [2];
    logic [31:0] g_d [2], g_wd [2];
    logic [3:0] g_we [2];
    logic [29:0] g_ad [2];
    logic g_er [2], g_to [2];
    int idx, x_en;
    bit x_to;
    e[0] = e0;
    e[1] = e1;
    for (int i = 0; i < 2; i++) begin
      en_n[i] = 0;
      rsp_n[i] = 0;
      rsp_c[i] = 0;
      g_d[i] = 32'h0;
      g_wd[i] = 32'h0;
      g_we[i] = 4'h0;
      g_ad[i] = 30'h0;
      g_er[i] = 1'b0;
      g_to[i] = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("%s/ready", nm), {30'h0, rdy}, 32'h3);
    req_valid = 1'b1;
    req_op = op;
    req_addr = a;
    req_wdata = wd;
    req_rt_old = rt;
    mem_rdata = rd;
    mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_ack = 1'b0;
    idx = 0;
    for (int c = 1; c <= TMO + 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (en[i]) begin
          if (en_n[i] == 0) begin
            g_we[i] = we[i];
            g_ad[i] = mad[i];
            g_wd[i] = mwd[i];
          end
          en_n[i]++;
        end
        if (rv[i]) begin
          if (rsp_n[i] == 0) begin
            rsp_c[i] = c;
            g_d[i] = rd_o[i];
            g_er[i] = er[i];
            g_to[i] = tm[i];
          end
          rsp_n[i]++;
        end
      end
      mem_ack = en[0] && idx == ack_at;
      if (en[0]) idx++;
    end
    mem_ack = 1'b0;
    x_to = !e0.err && (ack_at < 0 || ack_at > TMO);
    x_en = e0.err ? 0 : x_to ? TMO + 1 : ack_at + 1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s/dut%0d/rsp_pulses", nm, i), rsp_n[i], 1);
      chk($sformatf("%s/dut%0d/rsp_cycle", nm, i), rsp_c[i], e[i].err ? 1 : x_en + 1);
      chk($sformatf("%s/dut%0d/rsp_err", nm, i), {31'h0, g_er[i]}, {31'h0, e[i].err});
      chk($sformatf("%s/dut%0d/rsp_timeout", nm, i), {31'h0, g_to[i]}, {31'h0, x_to});
      chk($sformatf("%s/dut%0d/rsp_data", nm, i), g_d[i], x_to ? 32'h0 : e[i].data);
      chk($sformatf("%s/dut%0d/mem_en_cycles", nm, i), en_n[i], x_en);
      if (x_en > 0) begin
        chk($sformatf("%s/dut%0d/mem_addr", nm, i), {2'b0, g_ad[i]}, a >> 2);
        chk($sformatf("%s/dut%0d/mem_we", nm, i), {28'h0, g_we[i]}, {28'h0, e[i].we});
        if (e[i].we != 4'h0) chk($sformatf("%s/dut%0d/mem_wdata", nm, i), g_wd[i], e[i].wd);
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    vec_t tbl [14];
    logic [5:0] pool [12];
    exp_t te, tb_be;
    logic [5:0] op;
    logic [31:0] a, wd, rt, rd;
    int ack, pulses, ens;
    tbl[0]  = '{6'h20, 32'h1001, 32'h0, 32'h0, 32'h1234_80FF, 0, 32'hFFFF_FF80, 1'b0, 4'h0, 32'h0};
    tbl[1]  = '{6'h24, 32'h1001, 32'h0, 32'h0, 32'h1234_80FF, 0, 32'h0000_0080, 1'b0, 4'h0, 32'h0};
    tbl[2]  = '{6'h29, 32'h2002, 32'hAAAA_BEEF, 32'h0, 32'h0, 0, 32'h0, 1'b0, 4'hC, 32'hBEEF_BEEF};
    tbl[3]  = '{6'h23, 32'h3001, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 4'h0, 32'h0};
    tbl[4]  = '{6'h3F, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 4'h0, 32'h0};
    tbl[5]  = '{6'h23, 32'h3000, 32'h0, 32'h0, 32'h1111_2222, -1, 32'h0, 1'b0, 4'h0, 32'h0};
    tbl[6]  = '{6'h23, 32'h3004, 32'h0, 32'h0, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0};
`ifdef LSU_UNALIGNED_EN
    tbl[7]  = '{6'h22, 32'h1, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 32'h2211_CCDD, 1'b0, 4'h0, 32'h0};
    tbl[8]  = '{6'h26, 32'h2, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 1, 32'hAABB_4433, 1'b0, 4'h0, 32'h0};
`else
    tbl[7]  = '{6'h22, 32'h1, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 32'h0, 1'b1, 4'h0, 32'h0};
    tbl[8]  = '{6'h26, 32'h2, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 1, 32'h0, 1'b1, 4'h0, 32'h0};
`endif
    tbl[9]  = '{6'h28, 32'h7, 32'h1234_56A5, 32'h0, 32'h0, 2, 32'h0, 1'b0, 4'h8, 32'hA5A5_A5A5};
    tbl[10] = '{6'h2B, 32'h10, 32'hCAFE_F00D, 32'h0, 32'h0, 3, 32'h0, 1'b0, 4'hF, 32'hCAFE_F00D};
    tbl[11] = '{6'h21, 32'h2, 32'h0, 32'h0, 32'h8001_7FFF, 1, 32'hFFFF_8001, 1'b0, 4'h0, 32'h0};
    tbl[12] = '{6'h25, 32'h0, 32'h0, 32'h0, 32'h8001_F00F, 0, 32'h0000_F00F, 1'b0, 4'h0, 32'h0};
    tbl[13] = '{6'h29, 32'h1, 32'h1234_5678, 32'h0, 32'h0, 0, 32'h0, 1'b1, 4'h0, 32'h0};
    pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset/req_ready", {30'h0, rdy}, 32'h3);
    chk("reset/mem_en", {30'h0, en}, 32'h0);
    chk("reset/rsp_valid", {30'h0, rv}, 32'h0);
    chk("reset/rsp_err", {30'h0, er}, 32'h0);
    chk("reset/rsp_timeout", {30'h0, tm}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset/dut%0d/mem_we", i), {28'h0, we[i]}, 32'h0);
      chk($sformatf("reset/dut%0d/mem_addr", i), {2'b0, mad[i]}, 32'h0);
      chk($sformatf("reset/dut%0d/mem_wdata", i), mwd[i], 32'h0);
      chk($sformatf("reset/dut%0d/rsp_data", i), rd_o[i], 32'h0);
    end
    for (int k = 0; k < 14; k++) begin
      te.data = tbl[k].data;
      te.err = tbl[k].err;
      te.we = tbl[k].we;
      te.wd = tbl[k].mwd;
      run_txn($sformatf("vec%0d", k), tbl[k].op, tbl[k].a, tbl[k].wd, tbl[k].rt, tbl[k].rd, tbl[k].ack,
              te, model(tbl[k].op, tbl[k].a, tbl[k].wd, tbl[k].rt, tbl[k].rd, 1'b1));
    end
    te = '{data: 32'h0, err: 1'b0, we: 4'hC, wd: 32'hBEEF_BEEF};
    tb_be = '{data: 32'h0, err: 1'b0, we: 4'h3, wd: 32'hBEEF_BEEF};
    run_txn("sh_endian", 6'h29, 32'h2002, 32'hAAAA_BEEF, 32'h0, 32'h0, 1, te, tb_be);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 6'h23;
    req_addr = 32'h40;
    mem_rdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait/mem_en_before", {30'h0, en}, 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_wait/mem_en_after", {30'h0, en}, 32'h0);
    chk("rst_wait/req_ready", {30'h0, rdy}, 32'h3);
    chk("rst_wait/rsp_valid", {30'h0, rv}, 32'h0);
    pulses = 0;
    ens = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv != 2'b00) pulses++;
      if (en != 2'b00) ens++;
      mem_ack = c == 1;
    end
    mem_ack = 1'b0;
    chk("rst_wait/stray_ack_rsp", pulses, 0);
    chk("rst_wait/stray_ack_en", ens, 0);
    run_txn("rst_wait/recover", 6'h23, 32'h44, 32'h0, 32'h0, 32'h0BAD_F00D, 0,
            model(6'h23, 32'h44, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0),
            model(6'h23, 32'h44, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b1));
    for (int k = 0; k < 40; k++) begin
      op = pool[$urandom_range(0, 11)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom;
      rt = $urandom;
      rd = $urandom;
      ack = int'($urandom_range(0, 6)) - 1;
      run_txn($sformatf("rnd%0d", k), op, a, wd, rt, rd, ack, model(op, a, wd, rt, rd, 1'b0), model(op, a, wd, rt, rd, 1'b1));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequenced load/store unit for the MEM stage of the MIPS core.
- Accepts one load/store request per transaction and drives a word-wide data memory port with a req/ack handshake.
- Generates byte-lane write enables and sign/zero-extends load data into one registered response.
- Adds the following over the combinational load extender:
  - store-side lane steering;
  - misalignment and illegal-op detection;
  - variable-latency memory with a timeout watchdog;
  - endianness mode.

Parameters:
- ADDR_W, 32: byte address width; mem_addr drops bits [1:0].
- TIMEOUT, 255: max cycles in WAIT without mem_ack before abort; must be ≥1; counter width clog2(TIMEOUT+1).
- BIG_ENDIAN, 0: 0 means lane = addr[1:0]; 1 means lane = 3-addr[1:0] (halfword lane = addr[1]^1).

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: reset; synchronous, active-low.
- req_valid, in, 1: request present; op/addr/wdata/rt_old valid.
- req_ready, out, 1: unit idle; request accepted when valid&&ready.
- req_op, in, 6: MIPS opcode (LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B).
- req_addr, in, ADDR_W: effective byte address.
- req_wdata, in, 32: store data (rt).
- req_rt_old, in, 32: current rt value; used only by the optional feature.
- mem_en, out, 1: memory request, held until ack or timeout.
- mem_we, out, 4: byte-lane write enables; 0 for loads.
- mem_addr, out, ADDR_W-2: word address.
- mem_wdata, out, 32: lane-steered store data.
- mem_rdata, in, 32: read word, valid with mem_ack.
- mem_ack, in, 1: memory completion.
- rsp_valid, out, 1: one-cycle response pulse.
- rsp_data, out, 32: extended load result; 0 for stores/errors.
- rsp_err, out, 1: address/illegal-op error, qualified by rsp_valid.
- rsp_timeout, out, 1: watchdog abort, qualified by rsp_valid.

Behaviour:
- Reset:
  - state IDLE; all outputs 0 except req_ready=1.
  - Timeout counter 0; captured request cleared.
  - Reset mid-WAIT drops mem_en the next edge; a later stray mem_ack is ignored.
- FSM IDLE → WAIT → RESP → IDLE, plus IDLE → RESP on error. req_ready=1 only in IDLE.
- IDLE: on req_valid, latch op, addr, wdata and rt_old.
  - Error if the op is not in the legal list.
  - Error if a halfword op has addr[0]≠0 or a word op has addr[1:0]≠0.
  - On error: go to RESP with rsp_err=1, rsp_data=0; mem_en never asserts.
  - Otherwise: go to WAIT; mem_en, mem_addr, mem_we and mem_wdata are registered and asserted the cycle after acceptance.
- WAIT:
  - Outputs held stable; counter increments each cycle.
  - mem_ack: capture mem_rdata, deassert mem_en, go to RESP.
  - counter==TIMEOUT with no ack: deassert mem_en, go to RESP with rsp_timeout=1, rsp_data=0.
  - Ack and timeout in the same cycle: ack wins, rsp_timeout=0.
- RESP: rsp_valid=1 for exactly one cycle with registered rsp_data/err/timeout; then IDLE. A new request is accepted the following cycle.
- Latency: zero-wait memory (ack in the first mem_en cycle) gives acceptance at cycle 0, mem_en at cycle 1, rsp_valid at cycle 2. Each extra wait cycle adds 1.
- Store steering:
  - SB: byte replicated to all 4 lanes, mem_we = 1<<lane.
  - SH: halfword replicated to both halves, mem_we = 4'b0011 (hw lane 0) or 4'b1100 (hw lane 1).
  - SW: mem_we = 4'b1111, data unchanged.
- Load extraction:
  - LB/LBU select byte `lane`; LH/LHU select the halfword; LW is passthrough.
  - LB/LH sign-extend from the selected MSB; LBU/LHU zero-extend.
- mem_ack outside WAIT is ignored.

Optional Feature:
- Macro LSU_UNALIGNED_EN.
- When defined, ops LWL 0x22 and LWR 0x26 are legal, never misaligned, and merge the read word with req_rt_old. Let o = lane offset.
  - LWL: o=0 {rd[7:0],rt[23:0]}; o=1 {rd[15:0],rt[15:0]}; o=2 {rd[23:0],rt[7:0]}; o=3 rd.
  - LWR: o=0 rd; o=1 {rt[31:24],rd[31:8]}; o=2 {rt[31:16],rd[31:16]}; o=3 {rt[31:8],rd[31:24]}.
- When undefined, 0x22/0x26 are illegal and give rsp_err=1 with no memory access.

Test Plan:
- LB addr=0x1001, mem_rdata=0x1234_80FF, zero-wait ack → mem_we=0, mem_addr=0x400, rsp_data=0xFFFF_FF80 at cycle 2. The same request as LBU → 0x0000_0080.
- SH addr=0x2002, wdata=0xAAAA_BEEF → mem_we=4'b1100, mem_wdata=0xBEEF_BEEF, rsp_data=0. With BIG_ENDIAN=1 → mem_we=4'b0011.
- LW addr=0x3001 → rsp_err=1 at cycle 1, mem_en never high. Opcode 0x3F → rsp_err=1.
- LW with no ack, TIMEOUT=4 → mem_en high 5 cycles, rsp_timeout=1, rsp_data=0. Ack on the 5th WAIT cycle → rsp_timeout=0 with data returned.
- rst_n=0 for one cycle during WAIT (ack arriving 2 cycles later) → mem_en=0 after the edge, no rsp_valid, req_ready=1.
- With LSU_UNALIGNED_EN: LWL addr=0x1, rd=0x4433_2211, rt_old=0xAABB_CCDD → 0x2211_CCDD. LWR addr=0x2 → 0xAABB_4433.
